ui_debounce: RTL and testbench

UI_DEBOUNCE -- requirements
Module: ui_debounce

---
 rtl/ui_debounce_pkg.sv | 23 ++
 rtl/ui_debounce_if.sv | 37 +++
 rtl/ui_debounce_ch.sv | 119 +++++++++++
 rtl/ui_debounce.sv | 45 ++++
 tb/tb_ui_debounce.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ui_debounce_pkg.sv
// ----------------------------------------------------------------------------
// ui_debounce_pkg
// Purpose : Definitions shared by the UI input conditioning block. Holds the
//           per-channel debounce state encoding and the default timing
//           constants used by the top-level and channel parameters.
// Contents: ch_state_e              - channel FSM state (IDLE / COUNT)
//           DEBOUNCE_CYCLES_DEFAULT - stable cycles needed to accept a level
//                                     (1 ms at 12 MHz)
//           CNT_W_DEFAULT           - debounce counter width
// ----------------------------------------------------------------------------
package ui_debounce_pkg;

  // IDLE : synchronized input matches the held level, counter is zero.
  // COUNT: synchronized input differs, counter is timing the new level.
  typedef enum logic [0:0] {
    CH_IDLE  = 1'b0,
    CH_COUNT = 1'b1
  } ch_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 12000;
  localparam int CNT_W_DEFAULT           = 16;

endpackage : ui_debounce_pkg

// File: rtl/ui_debounce_if.sv
// ----------------------------------------------------------------------------
// ui_debounce_if
// Purpose : Bundles the pin-side and core-side signals of the UI debouncer so
//           a driver (pins/stimulus) and the debouncer can be wired as one.
// Signals : ui_raw  - asynchronous pin levels          (master -> slave)
//           bypass  - 1 = skip debounce               (master -> slave)
//           ui_in   - debounced levels                (slave -> master)
//           ui_rise - one-cycle 0->1 acceptance pulse (slave -> master)
//           ui_fall - one-cycle 1->0 acceptance pulse (slave -> master)
// ----------------------------------------------------------------------------
interface ui_debounce_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] ui_raw;
  logic             bypass;
  logic [WIDTH-1:0] ui_in;
  logic [WIDTH-1:0] ui_rise;
  logic [WIDTH-1:0] ui_fall;

  modport master (
    output ui_raw,
    output bypass,
    input  ui_in,
    input  ui_rise,
    input  ui_fall
  );

  modport slave (
    input  ui_raw,
    input  bypass,
    output ui_in,
    output ui_rise,
    output ui_fall
  );

endinterface : ui_debounce_if

// File: rtl/ui_debounce_ch.sv
// ----------------------------------------------------------------------------
// ui_debounce_ch
// Purpose : One conditioned input channel: 2-flop synchronizer, two-state
//           debounce FSM with a saturating-by-construction counter, and
//           registered rise/fall pulses aligned with the level change.
// Ports   : clk      - rising-edge clock
//           rst_n    - synchronous active-low reset
//           raw_i    - asynchronous pin level
//           bypass_i - 1 = follow the synchronized level every cycle
//           level_o  - debounced level
//           rise_o   - one-cycle pulse on an accepted 0->1 change
//           fall_o   - one-cycle pulse on an accepted 1->0 change
// ----------------------------------------------------------------------------
module ui_debounce_ch
  import ui_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic bypass_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Counter value on the cycle that completes the stable window. With a
  // one-cycle window this is 0, so IDLE accepts immediately.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  ch_state_e        state_q;

  logic             mismatch_s;
  logic             window_done_s;

  // Compare the synchronized level against the held level and the window end.
  always_comb begin
    mismatch_s    = sync2_q ^ level_q;
    window_done_s = (cnt_q == LAST_CNT);
  end

  // Synchronizer, debounce FSM, counter and edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= CH_IDLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;

      if (bypass_i) begin
        // Any pending count is dropped; the level tracks the synchronizer.
        state_q <= CH_IDLE;
        cnt_q   <= '0;
        if (mismatch_s) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          fall_q  <= ~sync2_q;
        end
      end else begin
        case (state_q)
          CH_IDLE: begin
            if (mismatch_s && window_done_s) begin
              level_q <= sync2_q;
              rise_q  <= sync2_q;
              fall_q  <= ~sync2_q;
              cnt_q   <= '0;
            end else if (mismatch_s) begin
              state_q <= CH_COUNT;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
            end
          end
          CH_COUNT: begin
            if (!mismatch_s) begin
              // Input returned before the window closed: glitch rejected.
              state_q <= CH_IDLE;
              cnt_q   <= '0;
            end else if (window_done_s) begin
              state_q <= CH_IDLE;
              cnt_q   <= '0;
              level_q <= sync2_q;
              rise_q  <= sync2_q;
              fall_q  <= ~sync2_q;
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : ui_debounce_ch

// File: rtl/ui_debounce.sv
// ----------------------------------------------------------------------------
// ui_debounce
// Purpose : Conditions WIDTH asynchronous UI pins into debounced levels plus
//           one-cycle rise/fall pulses. Each bit is an independent
//           ui_debounce_ch; the top only fans out the shared bypass control.
// Ports   : clk     - single clock, rising edge
//           rst_n   - synchronous active-low reset
//           ui_raw  - asynchronous package-pin levels
//           bypass  - 1 = skip debounce, pass synchronized levels
//           ui_in   - debounced levels
//           ui_rise - one-cycle pulse per bit on accepted 0->1
//           ui_fall - one-cycle pulse per bit on accepted 1->0
// ----------------------------------------------------------------------------
module ui_debounce
  import ui_debounce_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ui_raw,
  input  logic             bypass,
  output logic [WIDTH-1:0] ui_in,
  output logic [WIDTH-1:0] ui_rise,
  output logic [WIDTH-1:0] ui_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ui_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (ui_raw[i]),
      .bypass_i (bypass),
      .level_o  (ui_in[i]),
      .rise_o   (ui_rise[i]),
      .fall_o   (ui_fall[i])
    );
  end

endmodule : ui_debounce

// File: tb/tb_ui_debounce.sv
// ----------------------------------------------------------------------------
// tb_ui_debounce
// Purpose : Directed self-checking bench for ui_debounce with a 4-cycle
//           debounce window. Expected per-cycle outputs are queued when the
//           stimulus is applied and popped/compared one cycle at a time.
// ----------------------------------------------------------------------------
module tb_ui_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

  typedef struct {
    string      tag;
    logic [7:0] in_v;
    logic [7:0] rise_v;
    logic [7:0] fall_v;
  } exp_t;

  logic clk;
  logic rst_n;

  ui_debounce_if #(.WIDTH(W)) dbg_if ();

  ui_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_raw  (dbg_if.ui_raw),
    .bypass  (dbg_if.bypass),
    .ui_in   (dbg_if.ui_in),
    .ui_rise (dbg_if.ui_rise),
    .ui_fall (dbg_if.ui_fall)
  );

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] level_m;

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] in_v,
                          input logic [7:0] rise_v, input logic [7:0] fall_v);
    exp_t e;
    e.tag    = tag;
    e.in_v   = in_v;
    e.rise_v = rise_v;
    e.fall_v = fall_v;
    sb_q.push_back(e);
  endtask

  task automatic push_n(input string tag, input int n, input logic [7:0] in_v);
    for (int k = 0; k < n; k++) push_exp(tag, in_v, 8'h00, 8'h00);
  endtask

  // Advance one clock per queued entry and compare 1 time unit after the edge.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(e.tag, "ui_in",   dbg_if.ui_in,   e.in_v);
      check(e.tag, "ui_rise", dbg_if.ui_rise, e.rise_v);
      check(e.tag, "ui_fall", dbg_if.ui_fall, e.fall_v);
    end
  endtask

  // Apply a clean step and expect acceptance exactly lat edges later.
  task automatic settle(input string tag, input logic [7:0] raw_new, input int lat);
    logic [7:0] r;
    logic [7:0] f;
    r = raw_new & ~level_m;
    f = level_m & ~raw_new;
    dbg_if.ui_raw = raw_new;
    push_n(tag, lat - 1, level_m);
    push_exp(tag, raw_new, r, f);
    push_exp(tag, raw_new, 8'h00, 8'h00);
    level_m = raw_new;
    drain();
  endtask

  initial begin
    rst_n         = 1'b0;
    dbg_if.ui_raw = 8'h00;
    dbg_if.bypass = 1'b0;
    level_m       = 8'h00;

    // Reset state.
    push_n("reset", 2, 8'h00);
    drain();

    // Release reset with bit 0 held high: accepted 6 edges later.
    rst_n = 1'b1;
    settle("rise_b0", 8'h01, 2 + DC);

    // Three-cycle pulse on bit 3 is shorter than the window.
    dbg_if.ui_raw = 8'h09;
    push_n("glitch_hi", 3, 8'h01);
    drain();
    dbg_if.ui_raw = 8'h01;
    push_n("glitch_lo", 8, 8'h01);
    drain();

    // Opposite-direction changes on two bits, then swap back.
    settle("swap_to_80", 8'h80, 2 + DC);
    settle("swap_to_01", 8'h01, 2 + DC);

    // Bypass enabled with stable input: nothing moves.
    dbg_if.bypass = 1'b1;
    push_n("byp_on", 3, 8'h01);
    drain();
    settle("byp_clear", 8'h00, 3);
    settle("byp_a5",    8'hA5, 3);
    settle("byp_00",    8'h00, 3);

    // Bypass disabled with stable input: no spurious edge.
    dbg_if.bypass = 1'b0;
    push_n("byp_off", 4, 8'h00);
    drain();

    // Bypass asserted mid-count: pending count dropped, level taken next edge.
    dbg_if.ui_raw = 8'h02;
    push_n("midcnt", 4, 8'h00);
    drain();
    dbg_if.bypass = 1'b1;
    push_exp("midcnt_byp", 8'h02, 8'h02, 8'h00);
    push_exp("midcnt_byp", 8'h02, 8'h00, 8'h00);
    drain();
    level_m = 8'h02;
    dbg_if.bypass = 1'b0;
    push_n("midcnt_off", 3, 8'h02);
    drain();

    // Reset on the edge that would have accepted the change.
    dbg_if.ui_raw = 8'h10;
    push_n("rst_abort_cnt", 5, 8'h02);
    drain();
    rst_n = 1'b0;
    push_n("rst_abort", 2, 8'h00);
    drain();
    level_m = 8'h00;

    // After release the held input is accepted from scratch.
    rst_n = 1'b1;
    settle("rst_restart", 8'h10, 2 + DC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ui_debounce
